pulse_shaper: RTL and testbench
===============================

PULSE_SHAPER -- requirements
Module: pulse_shaper

Interface
REQ-001 The block SHALL have parameter HIGH_LEN, default 16, giving the pulse high time in clocks (≥1).
REQ-002 The block SHALL have parameter GAP_LEN, default 16, giving the minimum low time between pulses in clocks (≥1).
REQ-003 The block SHALL have parameter PEND_W, default 3, giving the width of the pending-event counter.
REQ-004 clk  input  1  clock, all logic on posedge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 trig  input  1  event strobe; each clock sampled high SHALL count as one event.
REQ-007 out_pulse  output  1  shaped pulse, driven directly from a flop, glitch-free.
REQ-008 busy  output  1  high while state≠IDLE or pending≠0.
REQ-009 pending  output  PEND_W  events queued but not yet started.
REQ-010 ovf  output  1  sticky event-dropped flag (present only with the macro in REQ-026).

Function
REQ-011 The FSM SHALL have states IDLE, HIGH, GAP; out_pulse SHALL be 1 exactly in HIGH.
REQ-012 Available events: avail = pending + trig; "start" SHALL mean consuming one available event.
REQ-013 IDLE: if avail≥1, next state SHALL be HIGH with a start; otherwise remain in IDLE.
REQ-014 Latency: trig high in cycle N while IDLE with pending=0 SHALL give out_pulse=1 in cycles N+1..N+HIGH_LEN.
REQ-015 HIGH SHALL last exactly HIGH_LEN clocks, then go to GAP.
REQ-016 GAP SHALL last exactly GAP_LEN clocks; on its last cycle, if avail≥1, next state SHALL be HIGH with a start, else IDLE.
REQ-017 Update rule: pending_next = pending + trig − start, with trig dropped when the result would exceed 2^PEND_W−1.
REQ-018 Simultaneous trig and start SHALL leave pending unchanged.
REQ-019 A dropped trig (pending saturated, no start that cycle) SHALL NOT affect the pulse train.
REQ-020 The phase counter SHALL be $clog2(max(HIGH_LEN,GAP_LEN)+1) bits wide and clear to 0 on every state change.
REQ-021 Parameter values HIGH_LEN<1, GAP_LEN<1 or PEND_W<1 SHALL cause an elaboration error.

Reset
REQ-022 Assertion of resetN=0 SHALL immediately force state IDLE, out_pulse=0, busy=0, pending=0, phase counter=0 and ovf=0, with no clock required.
REQ-023 Reset asserted mid-HIGH or mid-GAP SHALL abort the pulse and discard all queued events.
REQ-024 After reset release, the first trig SHALL obey REQ-014.

Configuration
REQ-025 Without the macro, output ovf SHALL NOT exist and dropped events SHALL be silent.
REQ-026 With PULSE_SHAPER_OVF_EN defined, ovf SHALL set on the cycle after the first dropped trig and hold until reset.

Structure
REQ-027 Package pinball_pkg SHALL hold the state enum type (IDLE, HIGH, GAP) and the default HIGH_LEN/GAP_LEN constants.
REQ-028 The saturating up/down pending counter SHALL be a sub-module named event_pend_cnt (inputs inc, dec; output count; saturates at both ends).
REQ-029 The FSM and the phase counter SHALL reside in pulse_shaper.

Verification (HIGH_LEN=16, GAP_LEN=16, PEND_W=3)
REQ-030 Reset, then idle 20 clocks -> out_pulse=0, busy=0, pending=0 (and ovf=0) throughout.
REQ-031 Single trig in cycle 10 -> out_pulse=1 in cycles 11..26 and 0 from cycle 27; busy=0 from cycle 43.
REQ-032 trig in cycles 10,11,12 -> three 16-clock pulses separated by 16-clock gaps; pending reads 1 at cycle 12, 2 at cycle 13, 1 after the second start and 0 after the third.
REQ-033 10 trigs in cycles 10..19 -> pending caps at 7; exactly 8 pulses emitted; ovf=1 from cycle 19 (macro on).
REQ-034 trig in the last GAP cycle with pending=0 -> next pulse starts the following cycle; pending stays 0.
REQ-035 resetN low in the 5th HIGH cycle with pending=3 -> out_pulse=0 and pending=0 immediately; no further pulses until a new trig.

Source files
------------

// File: rtl/pinball_pkg.sv
// pinball_pkg: shared state encoding and default timing for the pulse shaper.
package pinball_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
    localparam int HIGH_LEN_DEF = 16;
    localparam int GAP_LEN_DEF  = 16;
endpackage

// File: rtl/event_pend_cnt.sv
// event_pend_cnt: up/down counter of queued events, saturating at zero and all-ones.
module event_pend_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !(&count_q))
            count_d = count_q + 1'b1;
        else if (dec && !inc && (|count_q))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pulse_shaper.sv
// pulse_shaper: emits fixed-width pulses with a minimum gap, queueing extra trigger events.
// Define PULSE_SHAPER_OVF_EN to add the sticky ovf output flagging dropped events.
module pulse_shaper
    import pinball_pkg::*;
#(
    parameter int HIGH_LEN = HIGH_LEN_DEF,
    parameter int GAP_LEN  = GAP_LEN_DEF,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              trig,
    output logic              out_pulse,
    output logic              busy,
    output logic [PEND_W-1:0] pending
`ifdef PULSE_SHAPER_OVF_EN
    ,
    output logic              ovf
`endif
);
    localparam int PW = $clog2((HIGH_LEN > GAP_LEN ? HIGH_LEN : GAP_LEN) + 1);
    localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_LEN - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_LEN - 1);

    generate
        if (HIGH_LEN < 1 || GAP_LEN < 1 || PEND_W < 1) begin : g_bad_param
            $error("pulse_shaper: HIGH_LEN, GAP_LEN and PEND_W must all be >= 1");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          out_q, out_d;
    logic          avail, start;

    assign avail = trig || (|pending);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = avail ? HIGH : IDLE;
                start   = avail;
            end
            HIGH: state_d = (phase_q == HIGH_LAST) ? GAP : HIGH;
            GAP: if (phase_q == GAP_LAST) begin
                state_d = avail ? HIGH : IDLE;
                start   = avail;
            end
            default: state_d = IDLE;
        endcase
        phase_d = (state_d != state_q || state_q == IDLE) ? '0 : phase_q + 1'b1;
        out_d   = (state_d == HIGH);
    end

    // out_pulse comes from its own flop so the decode of state bits never glitches it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    event_pend_cnt #(.W(PEND_W)) u_pend (
        .clk   (clk),
        .resetN(resetN),
        .inc   (trig),
        .dec   (start),
        .count (pending)
    );

    assign out_pulse = out_q;
    assign busy      = (state_q != IDLE) || (|pending);

`ifdef PULSE_SHAPER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            ovf_q <= 1'b0;
        else if (trig && !start && (&pending))
            ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pulse_shaper.sv
// tb_pulse_shaper: directed checks of pulse timing, event queueing, saturation and reset.
module tb_pulse_shaper;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       trig = 1'b0;
    logic       out_pulse, busy;
    logic [2:0] pending;
`ifdef PULSE_SHAPER_OVF_EN
    logic       ovf;
`endif
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    logic prev = 1'b0;

    always #5 clk = ~clk;

    pulse_shaper #(.HIGH_LEN(16), .GAP_LEN(16), .PEND_W(3)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .trig     (trig),
        .out_pulse(out_pulse),
        .busy     (busy),
        .pending  (pending)
`ifdef PULSE_SHAPER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut;
        trig = 1'b0;
        resetN = 1'b0;
        @(posedge clk);
        #3;
        resetN = 1'b1;
        cyc = 0;
    endtask

    function automatic logic win(input int c, input int lo, input int hi);
        return c >= lo && c <= hi;
    endfunction

    initial begin
        // reset takes effect with no clock edge
        #1;
        chk("rst_out", out_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
`ifdef PULSE_SHAPER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        reset_dut;
        while (cyc < 20) begin
            tick;
            chk("idle_out", out_pulse, 0);
            chk("idle_busy", busy, 0);
            chk("idle_pend", pending, 0);
`ifdef PULSE_SHAPER_OVF_EN
            chk("idle_ovf", ovf, 0);
`endif
        end

        reset_dut;
        while (cyc < 50) begin
            trig = (cyc == 10);
            tick;
            chk("single_out", out_pulse, win(cyc, 11, 26));
            chk("single_busy", busy, win(cyc, 11, 42));
            chk("single_pend", pending, 0);
        end

        reset_dut;
        while (cyc < 110) begin
            trig = win(cyc, 10, 12);
            tick;
            chk("three_out", out_pulse, win(cyc, 11, 26) | win(cyc, 43, 58) | win(cyc, 75, 90));
            chk("three_busy", busy, win(cyc, 11, 106));
            chk("three_pend", pending, (cyc == 12) ? 1 : win(cyc, 13, 42) ? 2 : win(cyc, 43, 74) ? 1 : 0);
        end

        // burst of 10 overflows the 3-bit queue
        reset_dut;
        pulses = 0;
        prev = 1'b0;
        while (cyc < 300) begin
            trig = win(cyc, 10, 19);
            tick;
            if (out_pulse && !prev) pulses++;
            prev = out_pulse;
            if (cyc == 18 || cyc == 20) chk("sat_pend7", pending, 7);
            if (cyc == 43) chk("sat_pend6", pending, 6);
            if (cyc == 235) chk("sat_pend0", pending, 0);
`ifdef PULSE_SHAPER_OVF_EN
            chk("sat_ovf", ovf, cyc >= 19);
`endif
        end
        chk("sat_pulses", pulses, 8);
        chk("sat_busy", busy, 0);

        // trigger arriving on the final gap cycle
        reset_dut;
        while (cyc < 80) begin
            trig = (cyc == 10) || (cyc == 42);
            tick;
            chk("lastgap_out", out_pulse, win(cyc, 11, 26) | win(cyc, 43, 58));
            chk("lastgap_busy", busy, win(cyc, 11, 74));
            chk("lastgap_pend", pending, 0);
        end

        // asynchronous reset in the 5th HIGH cycle with three events queued
        reset_dut;
        while (cyc < 15) begin
            trig = win(cyc, 10, 13);
            tick;
        end
        trig = 1'b0;
        chk("abort_pre_out", out_pulse, 1);
        chk("abort_pre_pend", pending, 3);
        resetN = 1'b0;
        #1;
        chk("abort_out", out_pulse, 0);
        chk("abort_pend", pending, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk);
        #3;
        resetN = 1'b1;
        cyc = 0;
        while (cyc < 50) begin
            trig = (cyc == 32);
            tick;
            chk("post_out", out_pulse, win(cyc, 33, 48));
            chk("post_busy", busy, cyc >= 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
